// File: rtl/predecode_fetch_pkg.sv
// Shared definitions for the 6502 fetch/predecode stage: forced-BRK opcode
// and the interrupt-type encoding handed to the instruction controller.
package predecode_fetch_pkg;

  localparam logic [7:0] BRK_OPCODE_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    INT_NONE  = 2'b00,
    INT_IRQ   = 2'b01,
    INT_NMI   = 2'b10,
    INT_RESET = 2'b11
  } int_type_e;

endpackage

// File: rtl/predecode_fetch_opcode_length_decode.sv
// Combinational operand-length / short-instruction decode of a 6502 opcode.
// Shared with the disassembly monitor.
module opcode_length_decode
  import predecode_fetch_pkg::*;
(
  input  logic [7:0] op,
  output logic       one_byte,
  output logic       two_cycle
);

  logic stack_or_return;

  always_comb begin
    one_byte = (op[3:0] == 4'h8) | (op[3:0] == 4'hA) | (op == 8'h40) | (op == 8'h60);
    // Push/pull and RTI/RTS are single-byte but need more than T0+T1.
    stack_or_return = (op == 8'h08) | (op == 8'h28) | (op == 8'h48) |
                      (op == 8'h68) | (op == 8'h40) | (op == 8'h60);
    two_cycle = (one_byte & ~stack_or_return) | (op[4:0] == 5'b01001) |
                (op == 8'hA0) | (op == 8'hA2) | (op == 8'hC0) | (op == 8'hE0);
  end

endmodule

// File: rtl/predecode_fetch.sv
// Opcode fetch and predecode: registers the data bus into PD and swaps in a
// forced BRK on opcode fetches while a reset, NMI or IRQ is pending.
module predecode_fetch
  import predecode_fetch_pkg::*;
#(
  parameter logic [7:0] BRK_OPCODE = BRK_OPCODE_DEFAULT
) (
  input  logic       clk_ph1,
  input  logic       rst,
  input  logic [7:0] db_in,
  input  logic       rdy,
  input  logic       fetch,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       i_flag,
  input  logic       int_ack,
  output logic [7:0] PD,
  output logic       injected,
  output logic [1:0] int_type,
  output logic       one_byte,
  output logic       two_cycle
);

  logic       nmi_q, nmi_prev_q, irq_q;
  logic       nmi_latch_q, nmi_latch_d;
  logic       reset_pending_q, reset_pending_d;
  logic [7:0] pd_q, pd_d;
  logic       injected_q, injected_d;
  int_type_e  int_type_q, int_type_d;
  logic       one_byte_q, one_byte_d;
  logic       two_cycle_q, two_cycle_d;

  logic       nmi_edge, irq_req, dec_one_byte, dec_two_cycle;

  opcode_length_decode u_len_dec (
    .op        (db_in),
    .one_byte  (dec_one_byte),
    .two_cycle (dec_two_cycle)
  );

  always_comb begin
    nmi_edge        = nmi_prev_q & ~nmi_q;
    irq_req         = ~irq_q & ~i_flag;
    // Edges are captured even while stalled so a short NMI pulse is never lost.
    nmi_latch_d     = nmi_latch_q | nmi_edge;
    reset_pending_d = reset_pending_q;
    pd_d            = pd_q;
    injected_d      = injected_q;
    int_type_d      = int_type_q;
    one_byte_d      = one_byte_q;
    two_cycle_d     = two_cycle_q;
    if (rdy) begin
      if (int_ack && int_type_q == INT_NMI && !nmi_edge) nmi_latch_d = 1'b0;
      if (int_ack && int_type_q == INT_RESET) reset_pending_d = 1'b0;
      if (fetch && (reset_pending_q || nmi_latch_q || irq_req)) begin
        pd_d        = BRK_OPCODE;
        injected_d  = 1'b1;
        one_byte_d  = 1'b1;
        two_cycle_d = 1'b0;
        if (reset_pending_q)  int_type_d = INT_RESET;
        else if (nmi_latch_q) int_type_d = INT_NMI;
        else                  int_type_d = INT_IRQ;
      end else begin
        pd_d        = db_in;
        injected_d  = 1'b0;
        one_byte_d  = dec_one_byte;
        two_cycle_d = dec_two_cycle;
        if (fetch) int_type_d = INT_NONE;
      end
    end
  end

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      nmi_q           <= 1'b1;
      nmi_prev_q      <= 1'b1;
      irq_q           <= 1'b1;
      nmi_latch_q     <= 1'b0;
      reset_pending_q <= 1'b1;
      pd_q            <= 8'h00;
      injected_q      <= 1'b0;
      int_type_q      <= INT_NONE;
      one_byte_q      <= 1'b0;
      two_cycle_q     <= 1'b0;
    end else begin
      nmi_q           <= nmi_n;
      nmi_prev_q      <= nmi_q;
      irq_q           <= irq_n;
      nmi_latch_q     <= nmi_latch_d;
      reset_pending_q <= reset_pending_d;
      pd_q            <= pd_d;
      injected_q      <= injected_d;
      int_type_q      <= int_type_d;
      one_byte_q      <= one_byte_d;
      two_cycle_q     <= two_cycle_d;
    end
  end

  assign PD        = pd_q;
  assign injected  = injected_q;
  assign int_type  = int_type_q;
  assign one_byte  = one_byte_q;
  assign two_cycle = two_cycle_q;

endmodule

// File: tb/tb_predecode_fetch.sv
// Directed bench for predecode_fetch: reset injection, NMI/IRQ priority and
// latency, stall hold, async reset and a full opcode length-decode sweep.
module tb_predecode_fetch;

  logic       clk_ph1 = 1'b0;
  logic       rst;
  logic [7:0] db_in;
  logic       rdy, fetch, irq_n, nmi_n, i_flag, int_ack;
  logic [7:0] PD;
  logic       injected, one_byte, two_cycle;
  logic [1:0] int_type;

  int checks = 0;
  int errors = 0;

  predecode_fetch dut (
    .clk_ph1   (clk_ph1),
    .rst       (rst),
    .db_in     (db_in),
    .rdy       (rdy),
    .fetch     (fetch),
    .irq_n     (irq_n),
    .nmi_n     (nmi_n),
    .i_flag    (i_flag),
    .int_ack   (int_ack),
    .PD        (PD),
    .injected  (injected),
    .int_type  (int_type),
    .one_byte  (one_byte),
    .two_cycle (two_cycle)
  );

  always #5 clk_ph1 = ~clk_ph1;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_out(input string tag, input logic [7:0] pd, input logic inj,
                           input logic [1:0] it);
    check({tag, ".pd"}, PD, pd);
    check({tag, ".inj"}, {7'd0, injected}, {7'd0, inj});
    check({tag, ".int_type"}, {6'd0, int_type}, {6'd0, it});
  endtask

  task automatic check_len(input string tag, input logic ob, input logic tc);
    check({tag, ".one_byte"}, {7'd0, one_byte}, {7'd0, ob});
    check({tag, ".two_cycle"}, {7'd0, two_cycle}, {7'd0, tc});
  endtask

  // Reference length table written out per low nibble.
  function automatic logic [1:0] golden_len(input logic [7:0] op);
    logic ob, tc;
    ob = 1'b0;
    tc = 1'b0;
    case (op[3:0])
      4'h8: begin ob = 1'b1; tc = !(op == 8'h08 || op == 8'h28 || op == 8'h48 || op == 8'h68); end
      4'hA: begin ob = 1'b1; tc = 1'b1; end
      4'h9: tc = !op[4];
      4'h0: begin ob = (op == 8'h40 || op == 8'h60); tc = (op == 8'hA0 || op == 8'hC0 || op == 8'hE0); end
      4'h2: tc = (op == 8'hA2);
      default: ;
    endcase
    return {ob, tc};
  endfunction

  task automatic nmi_fall();
    nmi_n = 1'b1;
    ticks(2);
    nmi_n = 1'b0;
    ticks(2);
  endtask

  task automatic ack();
    fetch = 1'b0; int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    logic [1:0] g;
    rst = 1'b1; db_in = 8'h00; rdy = 1'b1; fetch = 1'b0;
    irq_n = 1'b1; nmi_n = 1'b1; i_flag = 1'b1; int_ack = 1'b0;
    ticks(2);
    check_out("reset", 8'h00, 1'b0, 2'b00);
    check_len("reset", 1'b0, 1'b0);
    rst = 1'b0;

    fetch = 1'b1; db_in = 8'hA9;
    tick();
    check_out("rst_fetch", 8'h00, 1'b1, 2'b11);
    check_len("rst_fetch", 1'b1, 1'b0);
    ack();
    check_out("rst_ack_hold", 8'hA9, 1'b0, 2'b11);
    fetch = 1'b1; db_in = 8'hA9;
    tick();
    check_out("lda_imm", 8'hA9, 1'b0, 2'b00);
    check_len("lda_imm", 1'b0, 1'b1);

    fetch = 1'b0;
    nmi_n = 1'b0;
    ticks(2);
    fetch = 1'b1;
    tick();
    check_out("nmi", 8'h00, 1'b1, 2'b10);
    fetch = 1'b0;
    nmi_n = 1'b1;
    ticks(2);
    nmi_n = 1'b0;
    tick();
    ack();
    fetch = 1'b1; db_in = 8'hEA;
    tick();
    check_out("nmi_set_wins", 8'h00, 1'b1, 2'b10);
    ack();
    fetch = 1'b1; db_in = 8'hEA;
    tick();
    check_out("nmi_cleared", 8'hEA, 1'b0, 2'b00);
    check_len("nop", 1'b1, 1'b1);

    fetch = 1'b0; irq_n = 1'b0; i_flag = 1'b1;
    tick();
    fetch = 1'b1; db_in = 8'hEA;
    tick();
    check_out("irq_masked", 8'hEA, 1'b0, 2'b00);
    i_flag = 1'b0;
    tick();
    check_out("irq", 8'h00, 1'b1, 2'b01);
    fetch = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
    ticks(2);

    irq_n = 1'b0; i_flag = 1'b0;
    nmi_fall();
    fetch = 1'b1;
    tick();
    check_out("nmi_over_irq", 8'h00, 1'b1, 2'b10);
    ack();
    fetch = 1'b1; db_in = 8'hA9;
    tick();
    check_out("irq_after_nmi", 8'h00, 1'b1, 2'b01);
    fetch = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
    ticks(2);

    db_in = 8'h4C;
    nmi_fall();
    check_out("pre_stall", 8'h4C, 1'b0, 2'b01);
    rdy = 1'b0; fetch = 1'b1; db_in = 8'h11;
    tick();
    check_out("stall_hold", 8'h4C, 1'b0, 2'b01);
    rdy = 1'b1;
    tick();
    check_out("stall_deferred", 8'h00, 1'b1, 2'b10);
    ack();

    db_in = 8'hFF;
    nmi_fall();
    check_out("pre_async", 8'hFF, 1'b0, 2'b10);
    #2 rst = 1'b1; nmi_n = 1'b1;
    #1;
    check_out("async_rst", 8'h00, 1'b0, 2'b00);
    tick();
    rst = 1'b0;
    fetch = 1'b1; db_in = 8'hEA;
    tick();
    check_out("post_rst_fetch", 8'h00, 1'b1, 2'b11);
    ack();
    fetch = 1'b1; db_in = 8'hEA;
    tick();
    check_out("nmi_discarded", 8'hEA, 1'b0, 2'b00);

    fetch = 1'b0;
    for (int i = 0; i < 256; i++) begin
      db_in = i[7:0];
      tick();
      g = golden_len(i[7:0]);
      check($sformatf("sweep_%02h.pd", i), PD, i[7:0]);
      check_len($sformatf("sweep_%02h", i), g[1], g[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/predecode_fetch.md
# predecode_fetch

Opcode fetch and predecode stage of the 6502 core. Captures the data bus into the predecode register PD every ready cycle. On opcode-fetch cycles, PD is replaced with a forced BRK (0x00) when a reset, NMI or IRQ is pending. Registers the interrupt type and operand-length flags consumed by the instruction controller, which latches PD into IR on its next T1.

## Interface

Parameters:
- BRK_OPCODE, 8'h00, opcode injected on interrupt/reset fetch

Ports:
- clk_ph1  in  1  phase-1 clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- db_in  in  8  external data bus
- rdy  in  1  1 = bus cycle valid; 0 = stall, all state except input samplers holds
- fetch  in  1  from timing logic: current cycle is an opcode fetch (the cycle before T1)
- irq_n  in  1  level-sensitive IRQ, active low
- nmi_n  in  1  edge-sensitive NMI, active on falling edge
- i_flag  in  1  processor status I bit; 1 masks IRQ
- int_ack  in  1  one-cycle pulse from sequencer when the vector fetch completes
- PD  out  8  predecode register
- injected  out  1  PD holds a forced BRK; PC increment must be inhibited
- int_type  out  2  active interrupt: 00 software BRK/none, 01 IRQ, 10 NMI, 11 RESET
- one_byte  out  1  PD opcode has no operand bytes
- two_cycle  out  1  PD opcode completes in T0+T1 (implied/accumulator/immediate)

## Operation

- Input samplers (update every clock, independent of rdy): nmi_q <= nmi_n; nmi_prev <= nmi_q; irq_q <= irq_n.
- NMI edge: nmi_prev=1 and nmi_q=0 sets nmi_latch.
- nmi_latch clears on int_ack with int_type=10. If a new edge coincides with that clear, the set wins.
- reset_pending sets on rst and clears on int_ack with int_type=11.
- irq_req = ~irq_q & ~i_flag. It is not latched: if IRQ is removed before a fetch, it is lost.
- rdy=1, fetch=0: PD <= db_in; injected <= 0; int_type unchanged.
- rdy=1, fetch=1, request pending: PD <= BRK_OPCODE; injected <= 1; int_type <= highest-priority request.
  - Priority: RESET > NMI > IRQ.
- rdy=1, fetch=1, no request: PD <= db_in; injected <= 0; int_type <= 00.
- rdy=0: PD, injected, int_type and predecode flags hold. A fetch in a stalled cycle is deferred, not dropped.
- int_type holds from the fetch until the next fetch; int_ack does not clear int_type.
- Predecode flags, registered with PD from the value loaded into PD:
  - one_byte = (op[3:0]==8) | (op[3:0]==A) | op==40 | op==60.
  - two_cycle = (one_byte & op not in {08,28,48,68,40,60}) | (op[4:0]==01001) | op in {A0,A2,C0,E0}.
  - Injected BRK: one_byte=1, two_cycle=0.

## Timing

- Reset values: PD=00, injected=0, int_type=00, one_byte=0, two_cycle=0, nmi_latch=0, reset_pending=1, nmi_q=nmi_prev=irq_q=1.
- PD latency: db_in sampled at edge N appears on PD after edge N (one register).
- NMI latency: nmi_n falls before edge N; nmi_q=0 after N; nmi_latch=1 after N+1; the first fetch at or after edge N+2 injects.
- IRQ latency: irq_n low before edge N; the fetch at edge N+1 or later injects, provided i_flag=0 at that fetch.
- First fetch after rst release always injects with int_type=11.
- rst asserted mid-instruction: all outputs return to reset values immediately (asynchronous). A pending NMI is discarded.

## Structure

- Shared core package: BRK opcode constant, int_type encodings (INT_NONE, INT_IRQ, INT_NMI, INT_RESET).
- One natural sub-module: opcode_length_decode (combinational op -> one_byte, two_cycle), reusable by the disassembly monitor.
- Remainder is flat: samplers, nmi_latch, reset_pending, PD register.

## Test plan

- Reset then fetch=1, rdy=1, db_in=A9 -> PD=00, injected=1, int_type=11; int_ack, next fetch with A9 -> PD=A9, injected=0, two_cycle=1.
- nmi_n high->low, fetch two cycles later -> PD=00, int_type=10; int_ack with a new NMI edge in the same cycle -> next fetch injects again with 10.
- irq_n=0 and i_flag=1 at fetch with db_in=EA -> PD=EA, injected=0; i_flag=0 at next fetch -> PD=00, int_type=01.
- NMI and IRQ both pending at one fetch -> int_type=10; after int_ack, next fetch with IRQ still low and i_flag=0 -> int_type=01.
- rdy=0 during fetch with NMI pending -> PD and int_type hold; rdy=1 the next cycle -> injection occurs.
- Opcode sweep 00..FF with no requests -> one_byte/two_cycle match the golden decode table (e.g. 48: 1/0, 0A: 1/1, A2: 0/1, AD: 0/0).
